multicycle_control: RTL

Main control unit for the multicycle MIPS core. A Moore state machine decodes `op`/`funct` from the instruction register and sequences every datapath control strobe: fetch, decode, execute, memory and writeback. It sits directly upstream of `Data_Path`. Its outputs connect one-to-one to the datapath control inputs, and it consumes the datapath's `op`, `funct` and `zero` outputs.

---
 rtl/control_pkg.sv | 63 ++++++
 rtl/alu_decoder.sv | 22 ++
 rtl/multicycle_control.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/control_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes, functs, mux selects.
// latency: n/a (types and constants only); backpressure: n/a.
package control_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWR  = 4'd4,
    S_EXEC_R = 4'd5,
    S_WB_R   = 4'd6,
    S_EXEC_I = 4'd7,
    S_EXEC_G = 4'd8,
    S_WB_I   = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] OP_GPIOIN = 6'h3B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REGB     = 2'd0;
  localparam logic [1:0] SRCB_FOUR     = 2'd1;
  localparam logic [1:0] SRCB_SEXT     = 2'd2;
  localparam logic [1:0] SRCB_SEXT_SH2 = 2'd3;

  localparam logic [1:0] PC_ALU_RES = 2'd0;
  localparam logic [1:0] PC_ALU_OUT = 2'd1;
  localparam logic [1:0] PC_JUMP    = 2'd2;
  localparam logic [1:0] PC_REGA    = 2'd3;

  localparam logic [1:0] DST_RT  = 2'd0;
  localparam logic [1:0] DST_RD  = 2'd1;
  localparam logic [1:0] DST_R31 = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MEM = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct to ALUControl decode; unknown functs fall back to ADD.
// latency: combinational; backpressure: none.
module alu_decoder
  import control_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_SLT:  alu_control = ALU_SLT;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath (PCen in BRANCH also follows zero).
// latency: outputs combinational from state, 2-4 cycles per instruction; backpressure: none.
module multicycle_control
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCen,
  output logic       IorD,
  output logic       Ori,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [2:0] ALUControl,
  output logic [3:0] state_o
);

  state_t     state_q, state_d;
  logic [2:0] r_alu_ctl;

  alu_decoder u_alu_decoder (
    .funct       (funct),
    .alu_control (r_alu_ctl)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = (funct == FN_JR) ? S_JR : S_EXEC_R;
          OP_ADDI:        state_d = S_EXEC_I;
          OP_GPIOIN:      state_d = S_EXEC_G;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_JAL:         state_d = S_JAL;
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_EXEC_R: state_d = S_WB_R;
      S_EXEC_I: state_d = S_WB_I;
      S_EXEC_G: state_d = S_WB_I;
      default:  state_d = S_FETCH;
    endcase
  end

  // Reset forces every strobe low so an aborted instruction commits nothing.
  always_comb begin
    PCen       = 1'b0;
    IorD       = 1'b0;
    Ori        = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REGB;
    PCSrc      = PC_ALU_RES;
    RegDst     = DST_RT;
    MemtoReg   = M2R_ALU;
    ALUControl = ALU_AND;
    state_o    = 4'd0;
    if (!reset) begin
      state_o = state_q;
      case (state_q)
        S_FETCH: begin
          IRWrite    = 1'b1;
          ALUSrcB    = SRCB_FOUR;
          ALUControl = ALU_ADD;
          PCen       = 1'b1;
        end
        S_DECODE: begin
          ALUSrcB    = SRCB_SEXT_SH2;
          ALUControl = ALU_ADD;
        end
        S_MEMADR, S_EXEC_I: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = SRCB_SEXT;
          ALUControl = ALU_ADD;
        end
        S_EXEC_G: begin
          Ori        = 1'b1;
          ALUSrcA    = 1'b1;
          ALUSrcB    = SRCB_SEXT;
          ALUControl = ALU_ADD;
        end
        S_MEMRD: begin
          IorD     = 1'b1;
          MemtoReg = M2R_MEM;
          RegWrite = 1'b1;
        end
        S_MEMWR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        S_EXEC_R: begin
          ALUSrcA    = 1'b1;
          ALUControl = r_alu_ctl;
        end
        S_WB_R: begin
          RegDst   = DST_RD;
          RegWrite = 1'b1;
        end
        S_WB_I: RegWrite = 1'b1;
        S_BRANCH: begin
          // op is still the branch opcode: IR is not rewritten until the next FETCH.
          ALUSrcA    = 1'b1;
          ALUControl = ALU_SUB;
          PCSrc      = PC_ALU_OUT;
          PCen       = (op == OP_BNE) ? ~zero : zero;
        end
        S_JUMP: begin
          PCSrc = PC_JUMP;
          PCen  = 1'b1;
        end
        S_JAL: begin
          PCSrc    = PC_JUMP;
          PCen     = 1'b1;
          RegDst   = DST_R31;
          MemtoReg = M2R_PC;
          RegWrite = 1'b1;
        end
        S_JR: begin
          PCSrc = PC_REGA;
          PCen  = 1'b1;
        end
        default: state_o = 4'd0;
      endcase
    end
  end

endmodule
